// File: rtl/hazard_ctrl.sv
// Hazard control for the ID_EX stage: load-use stalls, taken-branch flushes and
// multi-cycle data-memory waits with a timeout abort. Also counts stalled cycles.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rtaddr_i,
  input  logic [4:0]       ifid_rsaddr_i,
  input  logic [4:0]       ifid_rtaddr_i,
  input  logic             ifid_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;
  logic               memstall, loaduse;

  // Hazard detection and prioritised pipeline controls.
  always_comb begin
    memstall = ((state_q == StMemWait) && !dmem_ack_i) ||
               ((state_q == StRun) && dmem_req_i && !dmem_ack_i);
    loaduse  = idex_memread_i && (idex_rtaddr_i != 5'd0) &&
               ((idex_rtaddr_i == ifid_rsaddr_i) ||
                (ifid_uses_rt_i && (idex_rtaddr_i == ifid_rtaddr_i)));

    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;

    if (memstall) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
    end else if (loaduse) begin
      // Branch operands may depend on the load, so a taken branch waits.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM, wait counter and stall counter.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      StRun: begin
        wait_d = '0;
        if (dmem_req_i && !dmem_ack_i) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (dmem_ack_i) begin
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q == WaitW'(MEM_TIMEOUT - 1)) begin
          // Abort the access; the flag stays set until reset.
          state_d   = StRun;
          wait_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
    endcase

    if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
